pic_mailbox: RTL and testbench

Buffered command/response mailbox between the Atom bus window at #B400-#B406 and the AtoMMC PIC. Atom writes are queued with their register offset in a small FIFO and drained by the PIC over a 4-phase req/ack handshake, so the 6502 no longer stalls on PIC service time. PIC response bytes are posted into a holding register that the Atom reads back. A status register sits at offset 7. The block sits between the #B400 address decoder and the PIC port pins.

---
 rtl/pic_mailbox.sv | 156 +++++++++++++++
 tb/tb_pic_mailbox.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_mailbox.sv
// pic_mailbox: Atom #B400 command FIFO drained by the AtoMMC PIC, plus response holding register and status.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module pic_mailbox #(
   parameter int DEPTH = 4
) (
   input  logic       Atom_Phi2,
   input  logic       Atom_Reset,
   input  logic       Atom_Sel,
   input  logic       Atom_RnW,
   input  logic [2:0] Atom_Addr,
   input  logic [7:0] Atom_Din,
   output logic [7:0] Atom_Dout,
   output logic       Atom_Doe,
   output logic       PIC_Req,
   input  logic       PIC_Ack,
   output logic [2:0] PIC_Addr,
   output logic [7:0] PIC_Data,
   input  logic       PIC_RdStb,
   input  logic [7:0] PIC_RdData,
   output logic       Rd_Valid
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_OFFER    = 2'd1,
      S_WAIT_LOW = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [10:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          ovf_w_q, ovf_w_d, ovf_r_q, ovf_r_d;
   // [1:0] two-flop synchroniser, [2] previous synced value for edge detect
   logic [2:0]    ack_sync_q, stb_sync_q;

   logic wr_en, push_req, flush, data_rd, stat_rd;
   logic full, empty, ack_s, ack_rise, stb_rise, pop, push;
   logic [3:0] count_w;
   logic [2:0] level_sat;
   logic [7:0] status;

   assign wr_en    = Atom_Sel & ~Atom_RnW;
   assign push_req = wr_en & (Atom_Addr != 3'd7);
   assign flush    = wr_en & (Atom_Addr == 3'd7) & Atom_Din[0];
   assign data_rd  = Atom_Sel & Atom_RnW & (Atom_Addr != 3'd7);
   assign stat_rd  = Atom_Sel & Atom_RnW & (Atom_Addr == 3'd7);

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign ack_s    = ack_sync_q[1];
   assign ack_rise = ack_sync_q[1] & ~ack_sync_q[2];
   assign stb_rise = stb_sync_q[1] & ~stb_sync_q[2];
   assign pop      = (state_q == S_OFFER) & ack_rise & ~flush;
   // A simultaneous pop frees a slot, so a write into a full FIFO is still accepted
   assign push     = push_req & (~full | pop);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (!empty && !flush) state_d = S_OFFER;
         S_OFFER: begin
            if (flush)         state_d = ack_s ? S_WAIT_LOW : S_IDLE;
            else if (ack_rise) state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: if (!ack_s) state_d = (empty || flush) ? S_IDLE : S_OFFER;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Clears are applied first so that a same-edge capture or overflow wins
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      ovf_w_d    = ovf_w_q;
      ovf_r_d    = ovf_r_q;
      if (flush || stat_rd) begin
         ovf_w_d = 1'b0;
         ovf_r_d = 1'b0;
      end
      if (flush || data_rd) rd_valid_d = 1'b0;
      if (push_req && !push) ovf_w_d = 1'b1;
      if (stb_rise) begin
         rd_data_d  = PIC_RdData;
         rd_valid_d = 1'b1;
         if (rd_valid_q) ovf_r_d = 1'b1;
      end
   end

   always_ff @(negedge Atom_Phi2 or posedge Atom_Reset) begin
      if (Atom_Reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_w_q    <= 1'b0;
         ovf_r_q    <= 1'b0;
         ack_sync_q <= '0;
         stb_sync_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_w_q    <= ovf_w_d;
         ovf_r_q    <= ovf_r_d;
         ack_sync_q <= {ack_sync_q[1:0], PIC_Ack};
         stb_sync_q <= {stb_sync_q[1:0], PIC_RdStb};
      end
   end

   always_ff @(negedge Atom_Phi2) begin
      if (push) mem_q[wr_ptr_q] <= {Atom_Addr, Atom_Din};
   end

   assign count_w   = 4'(count_q);
   assign level_sat = (count_w > 4'd7) ? 3'd7 : count_w[2:0];
   assign status    = {rd_valid_q, full, empty, ovf_w_q, ovf_r_q, level_sat};

   assign Atom_Dout = (Atom_Addr == 3'd7) ? status : rd_data_q;
   assign Atom_Doe  = Atom_Sel & Atom_RnW & Atom_Phi2;
   assign PIC_Req   = (state_q == S_OFFER);
   assign PIC_Addr  = PIC_Req ? mem_q[rd_ptr_q][10:8] : 3'd0;
   assign PIC_Data  = PIC_Req ? mem_q[rd_ptr_q][7:0]  : 8'd0;
   assign Rd_Valid  = rd_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_pic_mailbox.sv
// tb_pic_mailbox: directed scenarios then randomized Atom/PIC traffic against a queue-based mailbox model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_pic_mailbox;
   localparam int DEPTH  = 4;
   localparam int OP_NONE = 0;
   localparam int OP_WR   = 1;
   localparam int OP_RD   = 2;

   logic       Atom_Phi2  = 1'b1;
   logic       Atom_Reset = 1'b1;
   logic       Atom_Sel   = 1'b0;
   logic       Atom_RnW   = 1'b1;
   logic [2:0] Atom_Addr  = 3'd0;
   logic [7:0] Atom_Din   = 8'd0;
   logic [7:0] Atom_Dout;
   logic       Atom_Doe;
   logic       PIC_Req;
   logic       PIC_Ack    = 1'b0;
   logic [2:0] PIC_Addr;
   logic [7:0] PIC_Data;
   logic       PIC_RdStb  = 1'b0;
   logic [7:0] PIC_RdData = 8'd0;
   logic       Rd_Valid;

   pic_mailbox #(.DEPTH(DEPTH)) dut (
      .Atom_Phi2  (Atom_Phi2),
      .Atom_Reset (Atom_Reset),
      .Atom_Sel   (Atom_Sel),
      .Atom_RnW   (Atom_RnW),
      .Atom_Addr  (Atom_Addr),
      .Atom_Din   (Atom_Din),
      .Atom_Dout  (Atom_Dout),
      .Atom_Doe   (Atom_Doe),
      .PIC_Req    (PIC_Req),
      .PIC_Ack    (PIC_Ack),
      .PIC_Addr   (PIC_Addr),
      .PIC_Data   (PIC_Data),
      .PIC_RdStb  (PIC_RdStb),
      .PIC_RdData (PIC_RdData),
      .Rd_Valid   (Rd_Valid)
   );

   always #5 Atom_Phi2 = ~Atom_Phi2;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: mailbox contents as a queue plus flags, events scheduled by edge number
   logic [10:0] m_q[$];
   bit          m_rv, m_ow, m_or;
   logic [7:0]  m_rd;
   int          ecnt = 0;
   int          pop_at[$];
   int          cap_at[$];
   logic [7:0]  cap_dat[$];

   function automatic logic [7:0] m_status();
      int lvl;
      lvl = m_q.size();
      return {m_rv, (lvl == DEPTH), (lvl == 0), m_ow, m_or, 3'((lvl > 7) ? 7 : lvl)};
   endfunction

   // PIC-side agents
   bit         ack_want = 0, stb_want = 0, auto_pic = 0, auto_stb = 0, stb_stop = 0;
   logic [7:0] stb_val  = 8'd0;
   int         pa_st = 0, pa_cnt = 0, pa_pop = 0, idle_wait = 0, sa_cnt = 0;
   logic [7:0] last_dout;

   task automatic pic_agent();
      case (pa_st)
         0: begin
            if (PIC_Req) begin
               chk("pic_head", {PIC_Addr, PIC_Data}, (m_q.size() > 0) ? m_q[0] : 11'h7FF);
               pa_cnt = $urandom_range(0, 3);
               pa_st = 1;
               idle_wait = 0;
            end else if (m_q.size() > 0) begin
               idle_wait++;
               if (idle_wait > 4) begin
                  chk("req_timeout", PIC_Req, 1);
                  idle_wait = 0;
               end
            end
         end
         1: begin
            chk("req_hold", PIC_Req, 1);
            if (pa_cnt == 0) begin
               ack_want = 1;
               pa_pop = ecnt + 4;
               pa_st = 2;
            end else pa_cnt--;
         end
         2: begin
            if (ecnt >= pa_pop) begin
               chk("req_fall", PIC_Req, 0);
               pa_cnt = $urandom_range(0, 2);
               pa_st = 3;
            end else chk("req_wait", PIC_Req, 1);
         end
         default: begin
            if (pa_cnt == 0) begin
               ack_want = 0;
               pa_st = 0;
               idle_wait = 0;
            end else pa_cnt--;
         end
      endcase
   endtask

   task automatic stb_agent();
      if (sa_cnt > 0) sa_cnt--;
      else if (stb_want) begin
         stb_want = 0;
         sa_cnt = 2;
      end else if (!stb_stop && $urandom_range(0, 7) == 0) begin
         stb_want = 1;
         stb_val = 8'($urandom);
         sa_cnt = 3;
      end
   endtask

   // One Atom cycle: entered just after a falling edge, returns just after the next one
   task automatic cyc(input int op, input logic [2:0] a, input logic [7:0] d);
      bit rd_d, rd_s, wr, fl, rv_old;
      Atom_Sel  = (op != OP_NONE);
      Atom_RnW  = (op != OP_WR);
      Atom_Addr = a;
      Atom_Din  = d;
      if (op == OP_NONE) begin
         Atom_RnW  = 1'($urandom_range(0, 1));
         Atom_Addr = 3'($urandom);
         Atom_Din  = 8'($urandom);
      end
      if (ack_want && !PIC_Ack) pop_at.push_back(ecnt + 3);
      PIC_Ack = ack_want;
      if (stb_want && !PIC_RdStb) begin
         cap_at.push_back(ecnt + 3);
         cap_dat.push_back(stb_val);
      end
      PIC_RdStb  = stb_want;
      PIC_RdData = stb_val;
      chk("doe_phi2_low", Atom_Doe, 0);
      #7;
      last_dout = Atom_Dout;
      chk("doe", Atom_Doe, Atom_Sel & Atom_RnW);
      chk("rd_valid", Rd_Valid, m_rv);
      if (m_q.size() == 0) chk("req_when_empty", PIC_Req, 0);
      if (op == OP_RD) begin
         if (a == 3'd7) chk("status", Atom_Dout, m_status());
         else           chk("rd_data", Atom_Dout, m_rd);
      end
      if (auto_pic) pic_agent();
      if (auto_stb) stb_agent();
      rd_d = (op == OP_RD) && (a != 3'd7);
      rd_s = (op == OP_RD) && (a == 3'd7);
      wr   = (op == OP_WR);
      fl   = wr && (a == 3'd7) && d[0];
      @(negedge Atom_Phi2);
      ecnt++;
      rv_old = m_rv;
      if (rd_s) begin m_ow = 0; m_or = 0; end
      if (rd_d) m_rv = 0;
      if (fl) begin m_q.delete(); m_rv = 0; m_ow = 0; m_or = 0; end
      if (pop_at.size() > 0 && pop_at[0] == ecnt) begin
         void'(pop_at.pop_front());
         if (!fl && m_q.size() > 0) void'(m_q.pop_front());
      end
      if (wr && a != 3'd7) begin
         if (m_q.size() < DEPTH) m_q.push_back({a, d});
         else m_ow = 1;
      end
      if (cap_at.size() > 0 && cap_at[0] == ecnt) begin
         void'(cap_at.pop_front());
         if (rv_old) m_or = 1;
         m_rv = 1;
         m_rd = cap_dat.pop_front();
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(OP_NONE, 3'd0, 8'd0);
   endtask

   task automatic wait_req(input string tag, input int max);
      int n;
      n = 0;
      while (!PIC_Req && n < max) begin
         cyc(OP_NONE, 3'd0, 8'd0);
         n++;
      end
      if (!PIC_Req) begin
         checks++;
         failures++;
         $display("FAIL %s: PIC_Req got 0 expected 1 within %0d cycles", tag, max);
      end
   endtask

   task automatic strobe(input logic [7:0] v);
      stb_val  = v;
      stb_want = 1;
      idle(3);
      stb_want = 0;
      idle(2);
   endtask

   task automatic do_reset();
      Atom_Sel   = 1'b0;
      Atom_Reset = 1'b1;
      #2;
      chk("rst_req", PIC_Req, 0);
      chk("rst_rv", Rd_Valid, 0);
      chk("rst_head", {PIC_Addr, PIC_Data}, 0);
      m_q.delete();
      m_rv = 0; m_ow = 0; m_or = 0; m_rd = 8'd0;
      pop_at.delete(); cap_at.delete(); cap_dat.delete();
      Atom_Reset = 1'b0;
      @(negedge Atom_Phi2);
      ecnt++;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge Atom_Phi2);
      #1;
      do_reset();

      // Reset state
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t1_status", last_dout, 8'h20);
      chk("t1_req", PIC_Req, 0);

      // Single command, PIC acks after 5 cycles
      cyc(OP_WR, 3'd3, 8'h5A);
      chk("t2_req_n", PIC_Req, 0);
      idle(1);
      chk("t2_req_n1", PIC_Req, 1);
      chk("t2_head", {PIC_Addr, PIC_Data}, {3'd3, 8'h5A});
      idle(5);
      ack_want = 1;
      idle(1); chk("t2_req_e1", PIC_Req, 1);
      idle(1); chk("t2_req_e2", PIC_Req, 1);
      idle(1); chk("t2_req_e3", PIC_Req, 0);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t2_status", last_dout, 8'h20);
      ack_want = 0;
      idle(3);

      // Overflow then in-order drain
      for (int i = 1; i <= 5; i++) cyc(OP_WR, 3'd1, 8'(i));
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t3_status_ovf", last_dout, 8'h54);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t3_status_clr", last_dout, 8'h44);
      for (int i = 1; i <= 4; i++) begin
         wait_req("t3_wait_req", 8);
         chk("t3_head", {PIC_Addr, PIC_Data}, {3'd1, 8'(i)});
         ack_want = 1;
         idle(3);
         chk("t3_req_fall", PIC_Req, 0);
         ack_want = 0;
      end
      idle(3);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t3_status_end", last_dout, 8'h20);

      // Response path
      stb_val = 8'hA7;
      stb_want = 1;
      idle(1); chk("t4_rv_e1", Rd_Valid, 0);
      idle(1); chk("t4_rv_e2", Rd_Valid, 0);
      idle(1); chk("t4_rv_e3", Rd_Valid, 1);
      stb_want = 0;
      idle(2);
      cyc(OP_RD, 3'd0, 8'd0);
      chk("t4_data", last_dout, 8'hA7);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t4_b7", last_dout[7], 0);
      strobe(8'h11);
      strobe(8'h22);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t4_b7_b3", {last_dout[7], last_dout[3]}, 2'b11);
      cyc(OP_RD, 3'd2, 8'd0);
      chk("t4_latest", last_dout, 8'h22);

      // Flush while offering
      strobe(8'h44);
      cyc(OP_WR, 3'd2, 8'h11);
      cyc(OP_WR, 3'd2, 8'h22);
      cyc(OP_WR, 3'd2, 8'h33);
      chk("t5_req", PIC_Req, 1);
      cyc(OP_WR, 3'd7, 8'h01);
      chk("t5_req_flush", PIC_Req, 0);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t5_status", last_dout, 8'h20);
      idle(2);

      // Reset in WAIT_LOW with Ack held high
      cyc(OP_WR, 3'd5, 8'h66);
      idle(1);
      chk("t6_req", PIC_Req, 1);
      ack_want = 1;
      idle(3);
      chk("t6_wait_low", PIC_Req, 0);
      do_reset();
      idle(4);
      chk("t6_req_stale", PIC_Req, 0);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("t6_status", last_dout, 8'h20);
      ack_want = 0;
      idle(3);
      cyc(OP_WR, 3'd4, 8'h77);
      chk("t6_req_n", PIC_Req, 0);
      idle(1);
      chk("t6_req_n1", PIC_Req, 1);
      chk("t6_head", {PIC_Addr, PIC_Data}, {3'd4, 8'h77});
      ack_want = 1;
      idle(3);
      chk("t6_req_fall", PIC_Req, 0);
      ack_want = 0;
      idle(3);

      // Randomized traffic with autonomous PIC agents
      auto_pic = 1;
      auto_stb = 1;
      for (int i = 0; i < 800; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 2)      cyc(OP_NONE, 3'd0, 8'd0);
         else if (r <= 5) cyc(OP_WR, 3'($urandom_range(0, 6)), 8'($urandom));
         else if (r == 6) cyc(OP_WR, 3'd7, 8'($urandom) & 8'hFE);
         else if (r == 7) cyc(OP_RD, 3'($urandom_range(0, 6)), 8'd0);
         else             cyc(OP_RD, 3'd7, 8'd0);
      end
      stb_stop = 1;
      for (int i = 0; i < 20 && (stb_want || sa_cnt > 0); i++) idle(1);
      begin
         int n;
         n = 0;
         while ((m_q.size() > 0 || pa_st != 0) && n < 300) begin
            idle(1);
            n++;
         end
         if (m_q.size() > 0 || pa_st != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0 within 300 cycles", m_q.size());
         end
      end
      idle(4);
      cyc(OP_RD, 3'd7, 8'd0);
      chk("final_empty", last_dout[5], 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
